mac_tile_dual: RTL and testbench

MAC_TILE_DUAL -- requirements
Module: mac_tile_dual

---
 rtl/mac_tile_dual.sv | 150 +++++++++++++++
 tb/tb_mac_tile_dual.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mac_tile_dual.sv
// Dual-mode systolic MAC tile: weight-stationary or output-stationary operation.
// Define MAC_TILE_SAT_EN to clamp additions to the signed psum range and raise acc_ovf.
module mac_tile_dual #(
  parameter int bw      = 4,
  parameter int psum_bw = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [bw-1:0]      in_w,
  input  logic [2:0]         inst_w,
  input  logic [psum_bw-1:0] in_n,
  input  logic               mode_select,
  output logic [bw-1:0]      out_e,
  output logic [2:0]         inst_e,
  output logic [psum_bw-1:0] out_s,
  output logic               valid_s,
  output logic               acc_ovf
);

  typedef enum logic [1:0] {IDLE, WS_RUN, OS_ACC, OS_DRAIN} state_t;

  state_t             state_q;
  logic [bw-1:0]      a_q, b_q, w_q;
  logic [psum_bw-1:0] c_q, acc_q;
  logic [2:0]         inst_q;
  logic               load_ready_q, pend_q, valid_q, ovf_q;

  logic signed [2*bw-1:0]    ws_prod_s, os_prod_s;
  logic signed [psum_bw-1:0] ws_ext_s, os_ext_s;
  logic [psum_bw:0]          ws_sum_s, os_sum_s;

  // Returns {overflow, sum}; overflow can only be set when saturation is built in.
  function automatic logic [psum_bw:0] add_chk(input logic signed [psum_bw-1:0] x,
                                               input logic signed [psum_bw-1:0] y);
`ifdef MAC_TILE_SAT_EN
    logic signed [psum_bw:0] s;
    s = (psum_bw+1)'(x) + (psum_bw+1)'(y);
    if (s[psum_bw] != s[psum_bw-1]) begin
      if (s[psum_bw]) add_chk = {1'b1, 1'b1, {(psum_bw-1){1'b0}}};
      else            add_chk = {1'b1, 1'b0, {(psum_bw-1){1'b1}}};
    end else begin
      add_chk = {1'b0, s[psum_bw-1:0]};
    end
`else
    logic signed [psum_bw-1:0] r;
    r = x + y;
    add_chk = {1'b0, r};
`endif
  endfunction

  assign ws_prod_s = $signed(a_q) * $signed(b_q);
  assign os_prod_s = $signed(a_q) * $signed(w_q);
  assign ws_ext_s  = psum_bw'(ws_prod_s);
  assign os_ext_s  = psum_bw'(os_prod_s);
  assign ws_sum_s  = add_chk($signed(c_q), ws_ext_s);
  assign os_sum_s  = add_chk($signed(acc_q), os_ext_s);

  assign out_e   = a_q;
  assign inst_e  = inst_q;
  assign valid_s = valid_q;
  assign acc_ovf = ovf_q;

  always_comb begin
    out_s = ws_sum_s[psum_bw-1:0];
    case (state_q)
      OS_ACC:   out_s = psum_bw'($signed(w_q));
      OS_DRAIN: out_s = acc_q;
      default:  out_s = ws_sum_s[psum_bw-1:0];
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      w_q          <= '0;
      c_q          <= '0;
      acc_q        <= '0;
      inst_q       <= 3'b000;
      load_ready_q <= 1'b1;
      pend_q       <= 1'b0;
      valid_q      <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      inst_q  <= {inst_w[2], inst_w[1], inst_w[0] & ~load_ready_q};
      valid_q <= 1'b0;
      pend_q  <= 1'b0;
      // A WS result flagged valid this cycle latches the sticky flag if it clamped.
      if (state_q == WS_RUN && valid_q && ws_sum_s[psum_bw]) ovf_q <= 1'b1;
      if (pend_q) begin
        acc_q <= os_sum_s[psum_bw-1:0];
        if (os_sum_s[psum_bw]) ovf_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (!inst_w[2] && !mode_select && (inst_w[0] || inst_w[1])) begin
            state_q <= WS_RUN;
            if (inst_w[0] && load_ready_q) begin
              b_q          <= in_w;
              load_ready_q <= 1'b0;
            end
            if (inst_w[1]) begin
              a_q     <= in_w;
              c_q     <= in_n;
              valid_q <= 1'b1;
            end
          end else if (!inst_w[2] && mode_select && inst_w[1]) begin
            state_q <= OS_ACC;
            a_q     <= in_w;
            w_q     <= in_n[bw-1:0];
            pend_q  <= 1'b1;
          end
        end
        WS_RUN: begin
          if (inst_w[2]) begin
            state_q      <= IDLE;
            load_ready_q <= 1'b1;
          end else begin
            if (inst_w[0] && load_ready_q) begin
              b_q          <= in_w;
              load_ready_q <= 1'b0;
            end
            if (inst_w[1]) begin
              a_q     <= in_w;
              c_q     <= in_n;
              valid_q <= 1'b1;
            end
          end
        end
        OS_ACC: begin
          if (inst_w[2]) begin
            state_q <= OS_DRAIN;
            valid_q <= 1'b1;
          end else if (inst_w[1]) begin
            a_q    <= in_w;
            w_q    <= in_n[bw-1:0];
            pend_q <= 1'b1;
          end
        end
        OS_DRAIN: begin
          acc_q   <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_tile_dual.sv
// Directed bench for mac_tile_dual: WS vector table plus OS, saturation and reset sequences.
module tb_mac_tile_dual;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  in_w;
  logic [2:0]  inst_w;
  logic [15:0] in_n;
  logic        mode_select;
  logic [3:0]  out_e;
  logic [2:0]  inst_e;
  logic [15:0] out_s;
  logic        valid_s, acc_ovf;

  logic        reset8;
  logic [3:0]  in_w8;
  logic [2:0]  inst_w8;
  logic [7:0]  in_n8;
  logic        mode8;
  logic [3:0]  out_e8;
  logic [2:0]  inst_e8;
  logic [7:0]  out_s8;
  logic        valid_s8, acc_ovf8;

  int total_cnt = 0;
  int pass_cnt  = 0;

  always #5 clk = ~clk;

  mac_tile_dual #(.bw(4), .psum_bw(16)) dut (
    .clk(clk), .reset(reset), .in_w(in_w), .inst_w(inst_w), .in_n(in_n),
    .mode_select(mode_select), .out_e(out_e), .inst_e(inst_e), .out_s(out_s),
    .valid_s(valid_s), .acc_ovf(acc_ovf));

  mac_tile_dual #(.bw(4), .psum_bw(8)) dut8 (
    .clk(clk), .reset(reset8), .in_w(in_w8), .inst_w(inst_w8), .in_n(in_n8),
    .mode_select(mode8), .out_e(out_e8), .inst_e(inst_e8), .out_s(out_s8),
    .valid_s(valid_s8), .acc_ovf(acc_ovf8));

`ifdef MAC_TILE_SAT_EN
  localparam logic [15:0] V7   = 16'h7FFF;
  localparam logic [15:0] V10  = 16'h7FFF;
  localparam logic        OVF  = 1'b1;
  localparam logic [7:0]  SAT8 = 8'h7F;
`else
  localparam logic [15:0] V7   = 16'h8014;
  localparam logic [15:0] V10  = 16'h8029;
  localparam logic        OVF  = 1'b0;
  localparam logic [7:0]  SAT8 = 8'h93;
`endif

  typedef struct {
    logic [2:0]  inst;
    logic [3:0]  w;
    logic [15:0] n;
    logic [15:0] exp_s;
    logic        exp_v;
    logic [2:0]  exp_ie;
    logic [3:0]  exp_e;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic apply(input logic [2:0] inst, input logic [3:0] w, input logic [15:0] n,
                       input logic m);
    inst_w = inst; in_w = w; in_n = n; mode_select = m;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    inst_w = 3'b000; in_w = 4'h0; in_n = 16'h0000; mode_select = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_out_s"}, 32'(out_s), 32'h0);
    chk({tag, "_valid"}, 32'(valid_s), 32'h0);
    chk({tag, "_inst_e"}, 32'(inst_e), 32'h0);
    chk({tag, "_out_e"}, 32'(out_e), 32'h0);
    chk({tag, "_ovf"}, 32'(acc_ovf), 32'h0);
  endtask

  initial begin
    vecs[0]  = '{3'b001, 4'h3, 16'h0000, 16'h0000, 1'b0, 3'b000, 4'h0, 1'b0};
    vecs[1]  = '{3'b001, 4'h5, 16'h0000, 16'h0000, 1'b0, 3'b001, 4'h0, 1'b0};
    vecs[2]  = '{3'b010, 4'h2, 16'h000A, 16'h0010, 1'b1, 3'b010, 4'h2, 1'b0};
    vecs[3]  = '{3'b010, 4'hD, 16'h0064, 16'h005B, 1'b1, 3'b010, 4'hD, 1'b0};
    vecs[4]  = '{3'b010, 4'h7, 16'hFFF0, 16'h0005, 1'b1, 3'b010, 4'h7, 1'b0};
    vecs[5]  = '{3'b000, 4'h0, 16'h0000, 16'h0005, 1'b0, 3'b000, 4'h7, 1'b0};
    vecs[6]  = '{3'b010, 4'h8, 16'h7FFF, 16'h7FE7, 1'b1, 3'b010, 4'h8, 1'b0};
    vecs[7]  = '{3'b010, 4'h7, 16'h7FFF, V7,       1'b1, 3'b010, 4'h7, 1'b0};
    vecs[8]  = '{3'b000, 4'h0, 16'h0000, V7,       1'b0, 3'b000, 4'h7, OVF};
    vecs[9]  = '{3'b100, 4'h0, 16'h0000, V7,       1'b0, 3'b100, 4'h7, OVF};
    vecs[10] = '{3'b001, 4'h6, 16'h0000, V10,      1'b0, 3'b000, 4'h7, OVF};
    vecs[11] = '{3'b010, 4'h1, 16'h0004, 16'h000A, 1'b1, 3'b010, 4'h1, OVF};
    vecs[12] = '{3'b011, 4'h2, 16'h0001, 16'h000D, 1'b1, 3'b011, 4'h2, OVF};

    reset8 = 1'b1; inst_w8 = 3'b000; in_w8 = 4'h0; in_n8 = 8'h00; mode8 = 1'b0;
    do_reset();
    reset8 = 1'b0;
    chk_zero("reset");

    for (int i = 0; i < 13; i++) begin
      apply(vecs[i].inst, vecs[i].w, vecs[i].n, 1'b0);
      chk($sformatf("ws%0d_out_s", i), 32'(out_s), 32'(vecs[i].exp_s));
      chk($sformatf("ws%0d_valid", i), 32'(valid_s), 32'(vecs[i].exp_v));
      chk($sformatf("ws%0d_inst_e", i), 32'(inst_e), 32'(vecs[i].exp_ie));
      chk($sformatf("ws%0d_out_e", i), 32'(out_e), 32'(vecs[i].exp_e));
      chk($sformatf("ws%0d_ovf", i), 32'(acc_ovf), 32'(vecs[i].exp_ovf));
    end

    // OS accumulate with mode_select toggled mid-run
    do_reset();
    apply(3'b010, 4'h1, 16'h0002, 1'b1);
    chk("os_wpass1", 32'(out_s), 32'h0002);
    chk("os_valid1", 32'(valid_s), 32'h0);
    apply(3'b010, 4'h2, 16'h0003, 1'b0);
    chk("os_wpass2", 32'(out_s), 32'h0003);
    apply(3'b010, 4'hF, 16'h0004, 1'b1);
    apply(3'b010, 4'h3, 16'h0003, 1'b0);
    chk("os_valid4", 32'(valid_s), 32'h0);
    apply(3'b100, 4'h0, 16'h0000, 1'b0);
    chk("os_drain", 32'(out_s), 32'h000D);
    chk("os_drain_v", 32'(valid_s), 32'h1);
    for (int k = 0; k < 3; k++) begin
      apply(3'b000, 4'h0, 16'h0000, 1'b1);
      chk($sformatf("os_post_v%0d", k), 32'(valid_s), 32'h0);
    end

    // Accumulator cleared by drain; negative weight passes through sign-extended
    apply(3'b010, 4'h2, 16'h0003, 1'b1);
    apply(3'b010, 4'h1, 16'h000E, 1'b1);
    chk("os_negw", 32'(out_s), 32'hFFFE);
    apply(3'b100, 4'h0, 16'h0000, 1'b1);
    chk("os_acc_clr", 32'(out_s), 32'h0004);
    chk("os_acc_clr_v", 32'(valid_s), 32'h1);
    apply(3'b000, 4'h0, 16'h0000, 1'b0);

    // Flush and execute together: the flush-cycle product is not accumulated
    apply(3'b010, 4'h3, 16'h0002, 1'b1);
    apply(3'b010, 4'h1, 16'h0005, 1'b1);
    apply(3'b110, 4'h7, 16'h0007, 1'b1);
    chk("fx_drain", 32'(out_s), 32'h000B);
    chk("fx_valid", 32'(valid_s), 32'h1);
    chk("fx_inst_e", 32'(inst_e), 32'h6);
    apply(3'b000, 4'h0, 16'h0000, 1'b0);
    chk("fx_post_v", 32'(valid_s), 32'h0);

    // Asynchronous reset mid-accumulation with acc = 13
    apply(3'b010, 4'h1, 16'h0002, 1'b1);
    apply(3'b010, 4'h2, 16'h0003, 1'b1);
    apply(3'b010, 4'hF, 16'h0004, 1'b1);
    apply(3'b010, 4'h3, 16'h0003, 1'b1);
    apply(3'b000, 4'h0, 16'h0000, 1'b1);
    chk("ar_pre_out_e", 32'(out_e), 32'h3);
    #2 reset = 1'b1;
    #1 chk_zero("ar");
    #1 reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      apply(3'b000, 4'h0, 16'h0000, 1'b1);
      chk($sformatf("ar_post_v%0d", k), 32'(valid_s), 32'h0);
    end
    chk("ar_post_out_s", 32'(out_s), 32'h0);

    // Narrow psum: three 7*7 products overflow 8 bits
    inst_w8 = 3'b010; in_w8 = 4'h7; in_n8 = 8'h07; mode8 = 1'b1;
    repeat (3) @(posedge clk);
    #1 inst_w8 = 3'b100;
    @(posedge clk); #1;
    chk("sat8_drain", 32'(out_s8), 32'(SAT8));
    chk("sat8_valid", 32'(valid_s8), 32'h1);
    chk("sat8_ovf", 32'(acc_ovf8), 32'(OVF));
    inst_w8 = 3'b000;
    @(posedge clk); #1;
    chk("sat8_post_v", 32'(valid_s8), 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
